// File: rtl/fifo_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arbiter_pkg
//   Shared definitions for the fifo_arbiter slice: default configuration,
//   read-sequencer state encoding and the layout of a stored FIFO item.
//   A stored item is packed {src, data}: data occupies the low DATA_W bits
//   and the source tag sits directly above it.
// ---------------------------------------------------------------------------
package fifo_arbiter_pkg;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_FIFO_SIZE = 10;

   // Read-side sequencer states
   typedef enum logic [1:0] {
      R_IDLE = 2'd0,   // free to issue a FIFO read
      R_WAIT = 2'd1,   // FIFO read data appears this cycle
      R_HOLD = 2'd2    // word presented, waiting for the consumer
   } rd_state_t;

   // Item field offsets: data at the bottom, source tag above it
   localparam int ITEM_DATA_LSB = 0;

   function automatic int item_src_lsb(input int data_w);
      return data_w;
   endfunction

   // Source-tag width; a single producer still gets one tag bit
   function automatic int src_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Occupancy counter width, able to hold the value depth itself
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//   Synchronous single-clock FIFO with a one-cycle registered read.
//   Storage is a plain array so it maps onto block RAM. Depth need not be a
//   power of two; pointers wrap explicitly at FIFO_SIZE-1.
// Ports:
//   CLOCK_50  clock
//   RST_N     synchronous active-low reset (pointers, count, data_out)
//   write     push data_in (ignored when full)
//   read      pop; the item appears on data_out after the next edge
//   data_in   item to push
//   data_out  registered read data
//   full      FIFO_SIZE items stored
//   empty     no items stored
// ---------------------------------------------------------------------------
module fifo #(
   parameter int ITEM_SIZE_BITS = 8,
   parameter int FIFO_SIZE      = 10
) (
   input  logic                      CLOCK_50,
   input  logic                      RST_N,
   input  logic                      write,
   input  logic                      read,
   input  logic [ITEM_SIZE_BITS-1:0] data_in,
   output logic [ITEM_SIZE_BITS-1:0] data_out,
   output logic                      full,
   output logic                      empty
);

   localparam int PTR_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
   localparam int CNT_W = $clog2(FIFO_SIZE + 1);

   logic [ITEM_SIZE_BITS-1:0] mem [FIFO_SIZE];
   logic [PTR_W-1:0]          wr_ptr_reg;
   logic [PTR_W-1:0]          rd_ptr_reg;
   logic [CNT_W-1:0]          count_reg;
   logic                      do_write;
   logic                      do_read;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_SIZE - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full     = (count_reg == CNT_W'(FIFO_SIZE));
   assign empty    = (count_reg == '0);
   assign do_write = write && !full;
   assign do_read  = read && !empty;

   // Storage has no reset so it stays a pure RAM
   always_ff @(posedge CLOCK_50) begin
      if (do_write) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         data_out   <= '0;
      end else begin
         if (do_write) begin
            wr_ptr_reg <= next_ptr(wr_ptr_reg);
         end
         if (do_read) begin
            data_out   <= mem[rd_ptr_reg];
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         end
         case ({do_write, do_read})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fifo_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_arbiter
//   Shares one fifo between NUM_REQ producers and one consumer.
//   Write side: round-robin pick among requesters, word stored with its
//   source index. Read side: a three-state sequencer that hides the fifo's
//   read latency and presents a registered valid/ready stream.
//   The fifo never sees a write and a read in the same cycle; when both are
//   possible a toggling turn bit decides who goes. Occupancy is tracked
//   here and is the only full/empty reference used.
// Ports:
//   CLOCK_50   clock
//   RST_N      synchronous active-low reset (also resets the fifo)
//   req        per-producer request, held with stable data until granted
//   req_data   producer k's word in [k*DATA_W +: DATA_W]
//   gnt        one-hot combinational grant; req[k]&gnt[k] accepts word k
//   out_valid  registered output-valid
//   out_data   registered payload
//   out_src    registered source index of out_data
//   out_ready  consumer accepts when out_valid&out_ready
//   occupancy  items currently stored in the fifo
// ---------------------------------------------------------------------------
module fifo_arbiter
   import fifo_arbiter_pkg::*;
#(
   parameter  int NUM_REQ   = DEF_NUM_REQ,
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int FIFO_SIZE = DEF_FIFO_SIZE,
   localparam int SRC_W     = src_width(NUM_REQ),
   localparam int CNT_W     = cnt_width(FIFO_SIZE)
) (
   input  logic                      CLOCK_50,
   input  logic                      RST_N,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [SRC_W-1:0]          out_src,
   input  logic                      out_ready,
   output logic [CNT_W-1:0]          occupancy
);

   localparam int ITEM_W  = SRC_W + DATA_W;
   localparam int SRC_LSB = item_src_lsb(DATA_W);

   logic [DATA_W-1:0] req_word [NUM_REQ];

   logic [SRC_W-1:0]  rr_last_reg;
   logic              turn_reg;
   logic [CNT_W-1:0]  occ_reg;
   rd_state_t         rd_state_reg, rd_state_next;
   logic              out_valid_reg, out_valid_next;
   logic [DATA_W-1:0] out_data_reg, out_data_next;
   logic [SRC_W-1:0]  out_src_reg, out_src_next;

   logic [SRC_W-1:0]  win_idx;
   logic              full, empty;
   logic              wr_cand, rd_cand, do_wr, do_rd;
   logic [ITEM_W-1:0] fifo_din, fifo_dout;
   logic              fifo_full, fifo_empty;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
         assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin: first requester after the last winner, wrapping
   always_comb begin
      int cand;
      cand    = 0;
      win_idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         // Scanning from farthest to nearest so the nearest hit wins
         cand = (int'(rr_last_reg) + i) % NUM_REQ;
         if (req[cand]) begin
            win_idx = SRC_W'(cand);
         end
      end
   end

   assign full    = (occ_reg == CNT_W'(FIFO_SIZE));
   assign empty   = (occ_reg == '0);
   assign wr_cand = RST_N && (|req) && !full;
   assign rd_cand = RST_N && (rd_state_reg == R_IDLE) && !empty;
   // On a conflict turn=0 lets the write through, turn=1 the read
   assign do_wr   = wr_cand && !(rd_cand && turn_reg);
   assign do_rd   = rd_cand && !(wr_cand && !turn_reg);
   assign fifo_din = {win_idx, req_word[win_idx]};

   always_comb begin
      gnt = '0;
      if (do_wr) begin
         gnt[win_idx] = 1'b1;
      end
   end

   // Read sequencer: next state and output registers
   always_comb begin
      rd_state_next  = rd_state_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_src_next   = out_src_reg;
      case (rd_state_reg)
         R_IDLE: begin
            if (do_rd) begin
               rd_state_next = R_WAIT;
            end
         end
         R_WAIT: begin
            out_valid_next = 1'b1;
            out_data_next  = fifo_dout[ITEM_DATA_LSB +: DATA_W];
            out_src_next   = fifo_dout[SRC_LSB +: SRC_W];
            rd_state_next  = R_HOLD;
         end
         R_HOLD: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               rd_state_next  = R_IDLE;
            end
         end
         default: rd_state_next = R_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RST_N) begin
         rr_last_reg   <= SRC_W'(NUM_REQ - 1);
         turn_reg      <= 1'b0;
         occ_reg       <= '0;
         rd_state_reg  <= R_IDLE;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_src_reg   <= '0;
      end else begin
         rd_state_reg  <= rd_state_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_src_reg   <= out_src_next;
         if (do_wr) begin
            rr_last_reg <= win_idx;
         end
         if (wr_cand && rd_cand) begin
            turn_reg <= !turn_reg;
         end
         if (do_wr) begin
            occ_reg <= occ_reg + CNT_W'(1);
         end else if (do_rd) begin
            occ_reg <= occ_reg - CNT_W'(1);
         end
      end
   end

   fifo #(
      .ITEM_SIZE_BITS (ITEM_W),
      .FIFO_SIZE      (FIFO_SIZE)
   ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .RST_N    (RST_N),
      .write    (do_wr),
      .read     (do_rd),
      .data_in  (fifo_din),
      .data_out (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Safety: exclusive fifo access, bounded count, fifo agrees with us
   always_ff @(posedge CLOCK_50) begin
      if (RST_N) begin
         assert (!(do_wr && do_rd));
         assert (!(do_wr && full));
         assert (!(do_rd && empty));
         assert (occ_reg <= CNT_W'(FIFO_SIZE));
         assert (fifo_full == full);
         assert (fifo_empty == empty);
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_src   = out_src_reg;
   assign occupancy = occ_reg;

endmodule

// File: tb/tb_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_arbiter
//   Self-checking bench for fifo_arbiter (NUM_REQ=4, DATA_W=8, FIFO_SIZE=10).
//   Accepted words are pushed to a scoreboard queue; a consumer process pops
//   and compares every out_valid&out_ready transfer. Each scenario task does
//   its own inline checks of grants, occupancy and output timing.
// ---------------------------------------------------------------------------
module tb_fifo_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int FIFO_SIZE = 10;
   localparam int SRC_W     = 2;
   localparam int CNT_W     = 4;

   logic                      CLOCK_50 = 1'b0;
   logic                      RST_N    = 1'b0;
   logic [NUM_REQ-1:0]        req      = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic [SRC_W-1:0]          out_src;
   logic                      out_ready = 1'b0;
   logic [CNT_W-1:0]          occupancy;

   logic [DATA_W-1:0]         word [NUM_REQ];
   logic [SRC_W+DATA_W-1:0]   sb [$];
   logic [SRC_W+DATA_W-1:0]   sb_exp;

   int tests_run    = 0;
   int tests_failed = 0;

   assign req_data = {word[3], word[2], word[1], word[0]};

   always #10 CLOCK_50 = ~CLOCK_50;

   fifo_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .FIFO_SIZE (FIFO_SIZE)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .RST_N     (RST_N),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   // Scoreboard consumer: one line per output transfer
   always @(negedge CLOCK_50) begin
      if (RST_N && out_valid && out_ready) begin
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL out_unexpected: got src=%0d data=%02h, required no output", out_src, out_data);
         end else begin
            sb_exp = sb.pop_front();
            if ({out_src, out_data} !== sb_exp) begin
               tests_failed++;
               $display("FAIL out_item: got src=%0d data=%02h, required src=%0d data=%02h",
                        out_src, out_data, sb_exp[DATA_W +: SRC_W], sb_exp[DATA_W-1:0]);
            end else begin
               $display("[TB] out src=%0d data=%02h", out_src, out_data);
            end
         end
      end
   end

   // Drive point: just after the active edge
   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Sample point: opposite edge
   task automatic smp();
      @(negedge CLOCK_50);
   endtask

   task automatic apply_reset();
      RST_N     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      sb.delete();
      cyc();
      cyc();
      RST_N = 1'b1;
   endtask

   // Waits until the design is empty and the scoreboard consumed
   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 150; i++) begin
         smp();
         if (occupancy == '0 && !out_valid && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      cyc();
   endtask

   task automatic test_reset();
      RST_N     = 1'b0;
      req       = '1;
      out_ready = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) word[k] = DATA_W'($urandom);
      cyc();
      cyc();
      smp();
      tests_run++;
      if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b required 0000", gnt); end
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      tests_run++;
      if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %02h required 00", out_data); end
      tests_run++;
      if (out_src !== 2'd0) begin tests_failed++; $display("FAIL reset_out_src: got %0d required 0", out_src); end
      tests_run++;
      if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d required 0", occupancy); end
      cyc();
      RST_N     = 1'b1;
      req       = '0;
      out_ready = 1'b0;
      smp();
      tests_run++;
      if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: got occ=%0d valid=%b required occ=0 valid=0", occupancy, out_valid);
      end
      cyc();
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      word[2]   = 8'hA5;
      req       = 4'b0100;
      smp();
      tests_run++;
      if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL single_gnt: got %b required 0100", gnt); end
      sb.push_back({2'd2, 8'hA5});
      cyc();
      req = '0;
      smp();   // t+1: read issued
      tests_run++;
      if (gnt !== 4'b0000 || occupancy !== 4'd1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_t1: got gnt=%b occ=%0d valid=%b required gnt=0000 occ=1 valid=0", gnt, occupancy, out_valid);
      end
      cyc();
      smp();   // t+2: data in flight
      tests_run++;
      if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_t2: got occ=%0d valid=%b required occ=0 valid=0", occupancy, out_valid);
      end
      cyc();
      smp();   // t+3: output valid
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency: got valid=%b required 1", out_valid); end
      cyc();
      smp();
      tests_run++;
      if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
         tests_failed++;
         $display("FAIL single_after: got valid=%b occ=%0d required valid=0 occ=0", out_valid, occupancy);
      end
      cyc();
   endtask

   task automatic test_fairness();
      int             exp_idx;
      int             grants;
      logic [NUM_REQ-1:0] exp_gnt;
      apply_reset();
      out_ready = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) word[k] = DATA_W'($urandom);
      req     = '1;
      exp_idx = 0;
      grants  = 0;
      for (int c = 0; c < 40; c++) begin
         smp();
         if (gnt !== '0) begin
            exp_gnt = NUM_REQ'(1) << exp_idx;
            tests_run++;
            if (gnt !== exp_gnt) begin
               tests_failed++;
               $display("FAIL fair_order: got %b required %b", gnt, exp_gnt);
            end
            sb.push_back({SRC_W'(exp_idx), word[exp_idx]});
            grants++;
            cyc();
            word[exp_idx] = DATA_W'($urandom);
            exp_idx = (exp_idx + 1) % NUM_REQ;
         end else begin
            cyc();
         end
      end
      smp();
      tests_run++;
      if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL fair_full_gnt: got %b required 0000", gnt); end
      tests_run++;
      if (occupancy !== 4'd10) begin tests_failed++; $display("FAIL fair_full_occ: got %0d required 10", occupancy); end
      // 10 stored plus the one parked in the output register
      tests_run++;
      if (grants != 11) begin tests_failed++; $display("FAIL fair_grants: got %0d required 11", grants); end
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL fair_hold_valid: got %b required 1", out_valid); end
      cyc();
   endtask

   task automatic test_full_drain();
      int  prev_occ;
      bit  done;
      for (int c = 0; c < 3; c++) begin
         smp();
         tests_run++;
         if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL full_no_write: got %b required 0000", gnt); end
         cyc();
      end
      req       = '0;
      out_ready = 1'b1;
      prev_occ  = 10;
      done      = 1'b0;
      for (int i = 0; i < 100; i++) begin
         smp();
         tests_run++;
         if (!(int'(occupancy) == prev_occ || int'(occupancy) == prev_occ - 1)) begin
            tests_failed++;
            $display("FAIL drain_step: got %0d required %0d or %0d", occupancy, prev_occ, prev_occ - 1);
         end
         prev_occ = int'(occupancy);
         if (occupancy == '0 && !out_valid && sb.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!done) begin tests_failed++; $display("FAIL drain_done: got %0d pending required 0", sb.size()); end
      cyc();
   endtask

   task automatic test_conflict();
      int  occ_exp;
      bit  exp_w;
      bit  ok;
      apply_reset();
      out_ready = 1'b1;
      word[0]   = DATA_W'($urandom);
      req       = 4'b0001;
      occ_exp   = 0;
      // Expected: write, write, read, then every fourth cycle a read wins
      for (int c = 0; c < 12; c++) begin
         smp();
         exp_w = ((c % 4) != 2);
         tests_run++;
         if (occupancy !== CNT_W'(occ_exp)) begin
            tests_failed++;
            $display("FAIL conflict_occ: cycle %0d got %0d required %0d", c, occupancy, occ_exp);
         end
         tests_run++;
         if (gnt !== (exp_w ? 4'b0001 : 4'b0000)) begin
            tests_failed++;
            $display("FAIL conflict_gnt: cycle %0d got %b required %b", c, gnt, exp_w ? 4'b0001 : 4'b0000);
         end
         occ_exp = exp_w ? occ_exp + 1 : occ_exp - 1;
         if (exp_w) sb.push_back({2'd0, word[0]});
         cyc();
         if (exp_w) word[0] = DATA_W'($urandom);
      end
      req = '0;
      wait_drain(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL conflict_drain: got %0d pending required 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit seen;
      out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         word[3] = DATA_W'($urandom);
         req     = 4'b1000;
         seen    = 1'b0;
         for (int i = 0; i < 20; i++) begin
            smp();
            if (gnt[3]) begin seen = 1'b1; break; end
            cyc();
         end
         tests_run++;
         if (!seen) begin tests_failed++; $display("FAIL bp_write_timeout: got no grant required gnt[3]"); end
         sb.push_back({2'd3, word[3]});
         cyc();
         req = '0;
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         smp();
         if (out_valid) begin seen = 1'b1; break; end
         cyc();
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL bp_valid_timeout: got valid=0 required 1"); end
      cyc();
      for (int i = 0; i < 5; i++) begin
         smp();
         tests_run++;
         if (out_valid !== 1'b1 || {out_src, out_data} !== sb[0] || occupancy !== 4'd2) begin
            tests_failed++;
            $display("FAIL bp_hold: got valid=%b item=%03h occ=%0d required valid=1 item=%03h occ=2",
                     out_valid, {out_src, out_data}, occupancy, sb[0]);
         end
         cyc();
      end
      out_ready = 1'b1;
      smp();   // handshake cycle h
      cyc();
      smp();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_h1: got valid=%b required 0", out_valid); end
      cyc();
      smp();
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_h2: got valid=%b required 0", out_valid); end
      cyc();
      smp();
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_h3: got valid=%b required 1", out_valid); end
      cyc();
      wait_drain(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL bp_drain: got %0d pending required 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit stop_now;
      bit granted;
      apply_reset();
      out_ready = 1'b0;
      word[1]   = DATA_W'($urandom);
      req       = 4'b0010;
      stop_now  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         smp();
         granted = gnt[1];
         if (granted) sb.push_back({2'd1, word[1]});
         stop_now = out_valid && (occupancy >= 4'd3) && granted;
         cyc();
         if (granted) word[1] = DATA_W'($urandom);
         if (stop_now) break;
      end
      req = '0;
      smp();
      tests_run++;
      if (occupancy !== 4'd4 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_load: got occ=%0d valid=%b required occ=4 valid=1", occupancy, out_valid);
      end
      cyc();
      out_ready = 1'b1;
      smp();   // handshake
      cyc();
      out_ready = 1'b0;
      smp();   // read issued
      cyc();
      smp();   // sequencer waiting on fifo data
      tests_run++;
      if (occupancy !== 4'd3 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_wait: got occ=%0d valid=%b required occ=3 valid=0", occupancy, out_valid);
      end
      RST_N = 1'b0;
      req   = '1;
      sb.delete();
      cyc();
      smp();
      tests_run++;
      if (out_valid !== 1'b0 || occupancy !== 4'd0 || gnt !== 4'b0000) begin
         tests_failed++;
         $display("FAIL mid_reset: got valid=%b occ=%0d gnt=%b required valid=0 occ=0 gnt=0000",
                  out_valid, occupancy, gnt);
      end
      cyc();
      RST_N   = 1'b1;
      word[1] = DATA_W'($urandom);
      word[3] = DATA_W'($urandom);
      req     = 4'b1010;
      smp();
      tests_run++;
      if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL mid_rr_first: got %b required 0010", gnt); end
      sb.push_back({2'd1, word[1]});
      cyc();
      req = 4'b1000;
      smp();
      tests_run++;
      if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL mid_rr_second: got %b required 1000", gnt); end
      sb.push_back({2'd3, word[3]});
      cyc();
      req       = '0;
      out_ready = 1'b1;
      wait_drain(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL mid_drain: got %0d pending required 0", sb.size()); end
   endtask

   initial begin
      for (int k = 0; k < NUM_REQ; k++) word[k] = '0;
      test_reset();
      test_single();
      test_fairness();
      test_full_drain();
      test_conflict();
      test_backpressure();
      test_reset_mid();
      tests_run++;
      if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: got %0d required 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Shares one `fifo` instance between NUM_REQ producers and a single consumer.
- Write side: round-robin arbiter that tags each accepted word with its source index.
- Read side: small sequencer that absorbs the FIFO's one-cycle read latency and presents a valid/ready output stream.
- Guarantees the FIFO never sees write and read in the same cycle; keeps its own authoritative occupancy count.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- DATA_W, 8, payload width per producer.
- FIFO_SIZE, 10, depth passed to the internal fifo.
- SRC_W (localparam), $clog2(NUM_REQ), source-tag width; FIFO item width = SRC_W+DATA_W, packed {src, data}.
- CNT_W (localparam), $clog2(FIFO_SIZE+1), occupancy counter width.

Ports:
- CLOCK_50  in  1  system clock.
- RST_N  in  1  reset: synchronous, active-low (also drives the internal fifo's RST_N).
- req  in  NUM_REQ  per-producer request; must stay high with stable data until granted.
- req_data  in  NUM_REQ*DATA_W  producer k's word in bits [k*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, combinational; req[k]&gnt[k] = word k accepted this cycle.
- out_valid  out  1  registered; output word present.
- out_data  out  DATA_W  registered payload.
- out_src  out  SRC_W  registered source index of out_data.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- occupancy  out  CNT_W  items currently stored in the FIFO.

Behaviour:
- Reset (RST_N=0 at posedge):
  - gnt=0, out_valid=0, out_data=0, out_src=0, occupancy=0.
  - rr_last=NUM_REQ-1, so index 0 has priority first; turn=0; read FSM=R_IDLE.
  - In-flight read discarded; the FIFO is cleared by the same reset.
- full = (occupancy==FIFO_SIZE); empty = (occupancy==0). The internal fifo's own full/empty flags are ignored.
- Write candidate: any req bit set and ~full.
  - Winner is the first set req index searching rr_last+1, rr_last+2, … modulo NUM_REQ.
- Read candidate: FSM in R_IDLE and ~empty.
- Conflict: both candidates in the same cycle.
  - turn=0 → write wins; turn=1 → read wins. turn toggles on every conflict.
  - The loser asserts nothing that cycle.
- On a write: fifo write=1, data_in={winner, req_data[winner]}, gnt[winner]=1, rr_last<=winner, occupancy+1.
- On a read: fifo read=1, occupancy-1, FSM → R_WAIT.
- Read FSM:
  - R_IDLE: issue read as above.
  - R_WAIT: fifo data_out now holds the item; latch it into out_data/out_src, out_valid<=1 → R_HOLD.
  - R_HOLD: when out_ready, out_valid<=0 → R_IDLE. Otherwise hold data stable; no back-to-back read while holding.
- Throughput:
  - Read: at most one item per 3 cycles.
  - Write: one per cycle when no conflict.
- Latency: a write in cycle t into an empty FIFO gives read issue at t+1, out_valid at t+3.
- Full: gnt stays 0; requests wait, no drop.
- Empty: no read issued; FSM idles.
- Wrap-around is handled by the fifo. The occupancy counter never exceeds FIFO_SIZE and never underflows; an assertion checks both.
- Fixed ordering: FIFO order is preserved; out_src reflects the true producer.

Decomposition:
- Shared package: localparams SRC_W, CNT_W; read-FSM state encoding R_IDLE=2'd0, R_WAIT=2'd1, R_HOLD=2'd2; item pack/unpack field offsets.
- One sub-module, natural: `fifo` (existing), instantiated with ITEM_SIZE_BITS=SRC_W+DATA_W, FIFO_SIZE=FIFO_SIZE.
- Round-robin picker stays inline; it is a pure function of req, rr_last and full.

Test Plan:
- Single producer: req[2]=1, data 8'hA5, out_ready=1 → gnt=4'b0100 for one cycle; out_valid at +3 cycles with out_data=8'hA5, out_src=2; occupancy returns to 0.
- Fairness: all four req held high continuously, out_ready=0 → grant order 0,1,2,3,0,1,… (turn alternation may insert read cycles); stops at occupancy=10, gnt=0 while full.
- Full then drain: 10 writes stored, out_ready=1 → 10 outputs in write order with correct src tags; occupancy counts 10→0; no eleventh write accepted while full.
- Conflict: FIFO holds 1 item, FSM in R_IDLE, req[0]=1 → never fifo write&read in the same cycle (assert); write and read alternate per turn; occupancy stays consistent.
- Backpressure: out_ready=0 for 5 cycles in R_HOLD → out_data/out_src stable, no further fifo reads; release → next item follows 3 cycles later.
- Reset mid-operation: RST_N=0 while in R_WAIT with occupancy=3 → next cycle out_valid=0, occupancy=0, FSM=R_IDLE, gnt=0; a subsequent write to req[1] is granted first (rr_last reset).
